// File: rtl/board_pkg.sv
// Shared types and defaults for the battleship board overlay.
// Provides the cell state encoding, the board FSM states, the VGA stream
// payload and the default colours.
package board_pkg;

  localparam int unsigned HV_W    = 11;
  localparam int unsigned RGB_W   = 12;
  localparam int unsigned POS_W   = 12;
  localparam int unsigned COORD_W = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHIP  = 2'd1,
    MISS  = 2'd2,
    HIT   = 2'd3
  } cell_state_t;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    PEND  = 2'd2
  } fsm_t;

  typedef struct packed {
    logic [HV_W-1:0]  vcount;
    logic             vsync;
    logic             vblnk;
    logic [HV_W-1:0]  hcount;
    logic             hsync;
    logic             hblnk;
    logic [RGB_W-1:0] rgb;
  } vga_t;

  localparam logic [RGB_W-1:0] LINE_RGB_DEF  = 12'hFFF;
  localparam logic [RGB_W-1:0] WATER_RGB_DEF = 12'h36C;
  localparam logic [RGB_W-1:0] SHIP_RGB_DEF  = 12'h777;
  localparam logic [RGB_W-1:0] MISS_RGB_DEF  = 12'h9BF;
  localparam logic [RGB_W-1:0] HIT_RGB_DEF   = 12'hF00;

endpackage

// File: rtl/board_mem.sv
// Cell-state storage: GRID_N^2 entries of 2 bits.
// Ports: clk; we/waddr/wdata single write port; rd_a_addr/rd_a_data
// (render lookup) and rd_b_addr/rd_b_data (toggle lookup), both async reads.
module board_mem
  import board_pkg::*;
#(
  parameter int unsigned GRID_N = 10
) (
  input  logic                                  clk,
  input  logic                                  we,
  input  logic [$clog2(GRID_N*GRID_N)-1:0]      waddr,
  input  cell_state_t                           wdata,
  input  logic [$clog2(GRID_N*GRID_N)-1:0]      rd_a_addr,
  output cell_state_t                           rd_a_data,
  input  logic [$clog2(GRID_N*GRID_N)-1:0]      rd_b_addr,
  output cell_state_t                           rd_b_data
);

  cell_state_t mem_q [GRID_N*GRID_N];

  // Contents are initialised by the owner's clear sweep, so no reset here.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rd_a_data = mem_q[rd_a_addr];
  assign rd_b_data = mem_q[rd_b_addr];

endmodule

// File: rtl/draw_board.sv
// Battleship board overlay stage on the pixel clock.
// Ports: clk, rst (async, active low); vga_in/vga_out video stream (2-cycle
// latency); mouse_xpos/ypos/left cursor and button; shoot_mode; clear pulse;
// wr_en/wr_x/wr_y/wr_state game-logic cell write; sel_valid/sel_x/sel_y with
// sel_ready handshake for shoot selections; busy while clearing.
module draw_board
  import board_pkg::*;
#(
  parameter int unsigned      GRID_N    = 10,
  parameter int unsigned      CELL_LOG2 = 5,
  parameter int unsigned      X0        = 64,
  parameter int unsigned      Y0        = 96,
  parameter logic [RGB_W-1:0] LINE_RGB  = LINE_RGB_DEF,
  parameter logic [RGB_W-1:0] WATER_RGB = WATER_RGB_DEF,
  parameter logic [RGB_W-1:0] SHIP_RGB  = SHIP_RGB_DEF,
  parameter logic [RGB_W-1:0] MISS_RGB  = MISS_RGB_DEF,
  parameter logic [RGB_W-1:0] HIT_RGB   = HIT_RGB_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  vga_t               vga_in,
  output vga_t               vga_out,
  input  logic [POS_W-1:0]   mouse_xpos,
  input  logic [POS_W-1:0]   mouse_ypos,
  input  logic               mouse_left,
  input  logic               shoot_mode,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [1:0]         wr_state,
  output logic               sel_valid,
  output logic [COORD_W-1:0] sel_x,
  output logic [COORD_W-1:0] sel_y,
  input  logic               sel_ready,
  output logic               busy
);

  localparam int unsigned      CELLS    = GRID_N * GRID_N;
  localparam int unsigned      IW       = $clog2(CELLS);
  localparam int unsigned      SPAN     = GRID_N << CELL_LOG2;
  localparam logic [POS_W-1:0] X_LO     = POS_W'(X0);
  localparam logic [POS_W-1:0] X_HI     = POS_W'(X0 + SPAN);
  localparam logic [POS_W-1:0] Y_LO     = POS_W'(Y0);
  localparam logic [POS_W-1:0] Y_HI     = POS_W'(Y0 + SPAN);
  localparam logic [POS_W-1:0] OFF_MASK = POS_W'((1 << CELL_LOG2) - 1);

  function automatic logic [IW-1:0] cell_index(input logic [COORD_W-1:0] col,
                                               input logic [COORD_W-1:0] row);
    return IW'(32'(row) * GRID_N + 32'(col));
  endfunction

  function automatic logic [RGB_W-1:0] cell_rgb(input cell_state_t s);
    case (s)
      SHIP:    return SHIP_RGB;
      MISS:    return MISS_RGB;
      HIT:     return HIT_RGB;
      default: return WATER_RGB;
    endcase
  endfunction

  // Mouse button synchroniser plus one extra stage for rising-edge detect.
  logic ml_s1_q, ml_s2_q, ml_s3_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ml_s1_q <= 1'b0;
      ml_s2_q <= 1'b0;
      ml_s3_q <= 1'b0;
    end else begin
      ml_s1_q <= mouse_left;
      ml_s2_q <= ml_s1_q;
      ml_s3_q <= ml_s2_q;
    end
  end

  // Click qualification and clicked-cell coordinates.
  logic               click_c, m_inside_c;
  logic [POS_W-1:0]   m_dx_c, m_dy_c;
  logic [COORD_W-1:0] m_col_c, m_row_c;
  assign click_c    = ml_s2_q & ~ml_s3_q;
  assign m_inside_c = (mouse_xpos >= X_LO) && (mouse_xpos < X_HI) &&
                      (mouse_ypos >= Y_LO) && (mouse_ypos < Y_HI);
  assign m_dx_c     = m_inside_c ? (mouse_xpos - X_LO) : '0;
  assign m_dy_c     = m_inside_c ? (mouse_ypos - Y_LO) : '0;
  assign m_col_c    = COORD_W'(m_dx_c >> CELL_LOG2);
  assign m_row_c    = COORD_W'(m_dy_c >> CELL_LOG2);

  logic wr_ok_c;
  assign wr_ok_c = wr_en && (32'(wr_x) < GRID_N) && (32'(wr_y) < GRID_N);

  // Render stage-1 geometry.
  logic [POS_W-1:0] px_c, py_c, dx_c, dy_c;
  logic             x_in_c, y_in_c, inside_c, line_c, draw_c;
  assign px_c     = POS_W'(vga_in.hcount);
  assign py_c     = POS_W'(vga_in.vcount);
  assign x_in_c   = (px_c >= X_LO) && (px_c < X_HI);
  assign y_in_c   = (py_c >= Y_LO) && (py_c < Y_HI);
  assign inside_c = x_in_c && y_in_c;
  assign dx_c     = inside_c ? (px_c - X_LO) : '0;
  assign dy_c     = inside_c ? (py_c - Y_LO) : '0;
  // Closing right/bottom edges sit one pixel past the last cell.
  assign line_c   = (inside_c && (((dx_c & OFF_MASK) == '0) || ((dy_c & OFF_MASK) == '0))) ||
                    ((px_c == X_HI) && y_in_c) || ((py_c == Y_HI) && x_in_c);
  assign draw_c   = (inside_c || line_c) && !vga_in.hblnk && !vga_in.vblnk;

  logic        mem_we;
  logic [IW-1:0] mem_waddr;
  cell_state_t mem_wdata, rd_a_data, rd_b_data;

  board_mem #(.GRID_N(GRID_N)) u_mem (
    .clk       (clk),
    .we        (mem_we),
    .waddr     (mem_waddr),
    .wdata     (mem_wdata),
    .rd_a_addr (cell_index(COORD_W'(dx_c >> CELL_LOG2), COORD_W'(dy_c >> CELL_LOG2))),
    .rd_a_data (rd_a_data),
    .rd_b_addr (cell_index(m_col_c, m_row_c)),
    .rd_b_data (rd_b_data)
  );

  // Render pipeline: stage 1 geometry + cell read, stage 2 colour select.
  vga_t        vga_s1_q, vga_s2_q;
  logic        draw_s1_q, line_s1_q;
  cell_state_t cell_s1_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_s1_q  <= '0;
      vga_s2_q  <= '0;
      draw_s1_q <= 1'b0;
      line_s1_q <= 1'b0;
      cell_s1_q <= EMPTY;
    end else begin
      vga_s1_q  <= vga_in;
      draw_s1_q <= draw_c;
      line_s1_q <= line_c;
      cell_s1_q <= rd_a_data;
      vga_s2_q  <= vga_s1_q;
      if (draw_s1_q) vga_s2_q.rgb <= line_s1_q ? LINE_RGB : cell_rgb(cell_s1_q);
    end
  end

  // Board FSM registers.
  fsm_t               state_q, state_d;
  logic [IW-1:0]      clr_idx_q, clr_idx_d;
  logic               sel_valid_q, sel_valid_d, busy_q, busy_d;
  logic [COORD_W-1:0] sel_x_q, sel_x_d, sel_y_q, sel_y_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= CLEAR;
      clr_idx_q   <= '0;
      sel_valid_q <= 1'b0;
      sel_x_q     <= '0;
      sel_y_q     <= '0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      sel_valid_q <= sel_valid_d;
      sel_x_q     <= sel_x_d;
      sel_y_q     <= sel_y_d;
      busy_q      <= busy_d;
    end
  end

  // Next state and cell write arbitration: clear sweep > wr_en > toggle.
  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    sel_valid_d = sel_valid_q;
    sel_x_d     = sel_x_q;
    sel_y_d     = sel_y_q;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = EMPTY;
    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        if (clr_idx_q == IW'(CELLS - 1)) state_d = RUN;
        else                             clr_idx_d = clr_idx_q + IW'(1);
      end
      RUN: begin
        if (wr_ok_c) begin
          mem_we    = 1'b1;
          mem_waddr = cell_index(wr_x, wr_y);
          mem_wdata = cell_state_t'(wr_state);
        end else if (click_c && m_inside_c && !shoot_mode &&
                     (rd_b_data == EMPTY || rd_b_data == SHIP)) begin
          mem_we    = 1'b1;
          mem_waddr = cell_index(m_col_c, m_row_c);
          mem_wdata = (rd_b_data == EMPTY) ? SHIP : EMPTY;
        end
        if (click_c && m_inside_c && shoot_mode) begin
          sel_x_d     = m_col_c;
          sel_y_d     = m_row_c;
          sel_valid_d = 1'b1;
          state_d     = PEND;
        end
      end
      PEND: begin
        if (wr_ok_c) begin
          mem_we    = 1'b1;
          mem_waddr = cell_index(wr_x, wr_y);
          mem_wdata = cell_state_t'(wr_state);
        end
        if (sel_ready) begin
          sel_valid_d = 1'b0;
          state_d     = RUN;
        end
      end
      default: state_d = CLEAR;
    endcase
    if (clear) begin
      state_d     = CLEAR;
      clr_idx_d   = '0;
      sel_valid_d = 1'b0;
    end
    busy_d = (state_d == CLEAR);
  end

  assign vga_out   = vga_s2_q;
  assign sel_valid = sel_valid_q;
  assign sel_x     = sel_x_q;
  assign sel_y     = sel_y_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_draw_board.sv
// Directed self-checking bench for draw_board with default parameters.
module tb_draw_board;
  import board_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  vga_t         vga_in, vga_out;
  logic [11:0]  mouse_xpos, mouse_ypos;
  logic         mouse_left, shoot_mode, clear, wr_en, sel_ready;
  logic [3:0]   wr_x, wr_y, sel_x, sel_y;
  logic [1:0]   wr_state;
  logic         sel_valid, busy;

  int checks = 0;
  int errors = 0;

  draw_board dut (
    .clk        (clk),
    .rst        (rst),
    .vga_in     (vga_in),
    .vga_out    (vga_out),
    .mouse_xpos (mouse_xpos),
    .mouse_ypos (mouse_ypos),
    .mouse_left (mouse_left),
    .shoot_mode (shoot_mode),
    .clear      (clear),
    .wr_en      (wr_en),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_state   (wr_state),
    .sel_valid  (sel_valid),
    .sel_x      (sel_x),
    .sel_y      (sel_y),
    .sel_ready  (sel_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one active pixel and advance past the 2-cycle pipeline.
  task automatic pix(input int x, input int y, input logic [11:0] rgb_in);
    vga_in        = '0;
    vga_in.hcount = 11'(x);
    vga_in.vcount = 11'(y);
    vga_in.rgb    = rgb_in;
    tick();
    tick();
  endtask

  task automatic chk_cell(input string tag, input int c, input int r, input logic [11:0] exp);
    pix(64 + c * 32 + 5, 96 + r * 32 + 5, 12'h123);
    check(tag, 64'(vga_out.rgb), 64'(exp));
  endtask

  task automatic click(input int x, input int y);
    mouse_xpos = 12'(x);
    mouse_ypos = 12'(y);
    mouse_left = 1'b1;
    repeat (4) tick();
    mouse_left = 1'b0;
    repeat (4) tick();
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    vga_t v [4];
    int   n;

    vga_in     = '0;
    vga_in.rgb = 12'hABC;
    vga_in.hcount = 11'd100;
    mouse_xpos = '0;
    mouse_ypos = '0;
    mouse_left = 1'b0;
    shoot_mode = 1'b0;
    clear      = 1'b0;
    wr_en      = 1'b0;
    wr_x       = '0;
    wr_y       = '0;
    wr_state   = '0;
    sel_ready  = 1'b0;

    // Reset state.
    repeat (3) tick();
    check("rst_vga", 64'(vga_out), 64'(0));
    check("rst_sel_valid", 64'(sel_valid), 64'(0));
    check("rst_sel_xy", 64'({sel_x, sel_y}), 64'(0));
    check("rst_busy", 64'(busy), 64'(1));

    rst = 1'b1;
    wait_busy(n);
    check("busy_cycles", 64'(n), 64'(100));

    // Every field passes through with 2 cycles of delay.
    v[0] = '0; v[0].hcount = 11'd10;  v[0].vcount = 11'd10;  v[0].hsync = 1'b1; v[0].rgb = 12'h111;
    v[1] = '0; v[1].hcount = 11'd100; v[1].vcount = 11'd130; v[1].hblnk = 1'b1; v[1].rgb = 12'h222;
    v[2] = '0; v[2].hcount = 11'd200; v[2].vcount = 11'd200; v[2].vblnk = 1'b1; v[2].rgb = 12'h333;
    v[3] = '0; v[3].hcount = 11'd700; v[3].vcount = 11'd20;  v[3].vsync = 1'b1; v[3].rgb = 12'h444;
    for (int i = 0; i < 4; i++) begin
      vga_in = v[i];
      tick();
      if (i >= 1) check("vga_delay", 64'(vga_out), 64'(v[i-1]));
    end
    tick();
    check("vga_delay_last", 64'(vga_out), 64'(v[3]));

    chk_cell("cell00_water", 0, 0, 12'h36C);

    // Grid lines and edges.
    pix(64, 96, 12'h0AB);   check("line_corner", 64'(vga_out.rgb), 64'h0FFF);
    pix(63, 96, 12'h0AB);   check("outside_left", 64'(vga_out.rgb), 64'h00AB);
    pix(384, 150, 12'h0AB); check("right_edge", 64'(vga_out.rgb), 64'h0FFF);
    pix(100, 416, 12'h0AB); check("bottom_edge", 64'(vga_out.rgb), 64'h0FFF);
    pix(100, 417, 12'h0AB); check("below_board", 64'(vga_out.rgb), 64'h00AB);
    pix(128, 110, 12'h0AB); check("inner_vline", 64'(vga_out.rgb), 64'h0FFF);

    // Place mode toggles.
    click(100, 130);
    chk_cell("place_ship", 1, 1, 12'h777);
    click(100, 130);
    chk_cell("place_unship", 1, 1, 12'h36C);
    click(500, 500);
    chk_cell("outside_click", 1, 1, 12'h36C);
    check("outside_no_sel", 64'(sel_valid), 64'(0));

    // Shoot-mode selection handshake.
    shoot_mode = 1'b1;
    click(300, 400);
    check("sel_valid", 64'(sel_valid), 64'(1));
    check("sel_x", 64'(sel_x), 64'(7));
    check("sel_y", 64'(sel_y), 64'(9));
    repeat (5) tick();
    click(100, 130);
    check("pend_valid", 64'(sel_valid), 64'(1));
    check("pend_xy", 64'({sel_x, sel_y}), 64'({4'd7, 4'd9}));
    sel_ready = 1'b1;
    tick();
    check("sel_accept", 64'(sel_valid), 64'(0));
    sel_ready = 1'b0;

    // wr_en and toggle on cell (2,3) in the same cycle.
    shoot_mode = 1'b0;
    mouse_xpos = 12'd138;
    mouse_ypos = 12'd202;
    mouse_left = 1'b1;
    tick();
    tick();
    wr_en = 1'b1; wr_x = 4'd2; wr_y = 4'd3; wr_state = 2'd3;
    tick();
    wr_en = 1'b0;
    mouse_left = 1'b0;
    repeat (4) tick();
    chk_cell("wr_beats_toggle", 2, 3, 12'hF00);

    // Out-of-range write is dropped (would alias index 12 = cell (2,1)).
    wr_en = 1'b1; wr_x = 4'd12; wr_y = 4'd0; wr_state = 2'd3;
    tick();
    wr_en = 1'b0;
    chk_cell("wr_dropped", 2, 1, 12'h36C);

    // MISS colour, and a place click leaves MISS unchanged.
    wr_en = 1'b1; wr_x = 4'd4; wr_y = 4'd5; wr_state = 2'd2;
    tick();
    wr_en = 1'b0;
    chk_cell("miss_colour", 4, 5, 12'h9BF);
    click(64 + 4 * 32 + 9, 96 + 5 * 32 + 9);
    chk_cell("miss_kept", 4, 5, 12'h9BF);

    // Clear while a selection is pending.
    shoot_mode = 1'b1;
    click(300, 400);
    check("pend_before_clear", 64'(sel_valid), 64'(1));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_drops_sel", 64'(sel_valid), 64'(0));
    wait_busy(n);
    check("clear_busy_cycles", 64'(n), 64'(100));
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 10; c++) begin
        chk_cell("cleared_cell", c, r, 12'h36C);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
